// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   - ALU select codes driven onto alu_sel (the ALU itself is external)
//   - issue FSM state encoding
//   - result substituted for a divide by zero
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_DIV = 4'b0011;
    localparam logic [3:0] ALU_EQ  = 4'b1110;
    localparam logic [3:0] ALU_GT  = 4'b1111;

    localparam logic [3:0] DIV0_RESULT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 4 x 4-bit register file with asynchronous clear.
//   clk, rst_n              clock, asynchronous active-low clear
//   rd_a_addr/rd_a_data     combinational read port A
//   rd_b_addr/rd_b_data     combinational read port B
//   wb_en/wb_addr/wb_data   write-back port (wins on address collision)
//   ld_en/ld_addr/ld_data   direct load port
module alu_regfile
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] rd_a_addr,
    output logic [3:0] rd_a_data,
    input  logic [1:0] rd_b_addr,
    output logic [3:0] rd_b_data,
    input  logic       wb_en,
    input  logic [1:0] wb_addr,
    input  logic [3:0] wb_data,
    input  logic       ld_en,
    input  logic [1:0] ld_addr,
    input  logic [3:0] ld_data
);

    logic [3:0] regs_q [4];
    logic [3:0] wb_hit;
    logic [3:0] ld_hit;

    // Per-register write decode.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dec
        assign wb_hit[gi] = wb_en && (wb_addr == 2'(gi));
        assign ld_hit[gi] = ld_en && (ld_addr == 2'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                // Write-back is tested first so a same-address load is dropped.
                if (wb_hit[i]) begin
                    regs_q[i] <= wb_data;
                end else if (ld_hit[i]) begin
                    regs_q[i] <= ld_data;
                end
            end
        end
    end

    // Reads see pre-edge contents, so a load in the same cycle is not visible.
    assign rd_a_data = regs_q[rd_a_addr];
    assign rd_b_data = regs_q[rd_b_addr];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-command sequencer in front of a 4-bit combinational ALU.
//   cmd_*        command handshake and fields (select, dst, sources, immediate)
//   ld_*         direct register-file load port, usable in any state
//   alu_a/b/sel  registered operands/select to the external ALU
//   alu_result   combinational ALU output, sampled in EXEC
//   rsp_*        response handshake: data, dst, carry, zero, divide-error
module alu_issue
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_sel,
    input  logic [1:0] cmd_dst,
    input  logic [1:0] cmd_src_a,
    input  logic [1:0] cmd_src_b,
    input  logic       cmd_imm_en,
    input  logic [3:0] cmd_imm,
    input  logic       ld_en,
    input  logic [1:0] ld_addr,
    input  logic [3:0] ld_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [3:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic [1:0] rsp_dst,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       rsp_err
);

    state_t     state_q, state_d;
    logic       ready_q, ready_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [3:0] alu_sel_q, alu_sel_d;
    logic [1:0] dst_q, dst_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [3:0] rsp_data_q, rsp_data_d;
    logic [1:0] rsp_dst_q, rsp_dst_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_zero_q, rsp_zero_d;
    logic       rsp_err_q, rsp_err_d;

    logic [3:0] rd_a_data;
    logic [3:0] rd_b_data;
    logic       wb_en;
    logic       div0;
    logic       add_carry;
    logic [3:0] result;

    alu_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_a_addr (cmd_src_a),
        .rd_a_data (rd_a_data),
        .rd_b_addr (cmd_src_b),
        .rd_b_data (rd_b_data),
        .wb_en     (wb_en),
        .wb_addr   (dst_q),
        .wb_data   (result),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    assign div0      = (alu_sel_q == ALU_DIV) && (alu_b_q == 4'h0);
    assign add_carry = (alu_sel_q == ALU_ADD) &&
                       (({1'b0, alu_a_q} + {1'b0, alu_b_q}) > 5'd15);
    assign result    = div0 ? DIV0_RESULT : alu_result;

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        dst_d       = dst_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_dst_d   = rsp_dst_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;
        wb_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    alu_a_d   = rd_a_data;
                    alu_b_d   = cmd_imm_en ? cmd_imm : rd_b_data;
                    alu_sel_d = cmd_sel;
                    dst_d     = cmd_dst;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                wb_en       = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_data_d  = result;
                rsp_dst_d   = dst_q;
                rsp_carry_d = add_carry;
                rsp_zero_d  = (result == 4'h0);
                rsp_err_d   = div0;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered ready: low during reset, rises on the first edge after it.
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            alu_a_q     <= 4'h0;
            alu_b_q     <= 4'h0;
            alu_sel_q   <= 4'h0;
            dst_q       <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 4'h0;
            rsp_dst_q   <= 2'd0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            dst_q       <= dst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_dst_q   <= rsp_dst_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_dst   = rsp_dst_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_EQ  = 4'b1110;
    localparam logic [3:0] OP_GT  = 4'b1111;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] dst;
        logic       carry;
        logic       zero;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_sel;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_src_a;
    logic [1:0] cmd_src_b;
    logic       cmd_imm_en;
    logic [3:0] cmd_imm;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_sel;
    logic [3:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic [1:0] rsp_dst;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_err;

    int         chk_cnt = 0;
    int         err_cnt = 0;
    exp_t       sb_q[$];
    logic [3:0] model_rf [4];

    always #5 clk = ~clk;

    alu_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sel    (cmd_sel),
        .cmd_dst    (cmd_dst),
        .cmd_src_a  (cmd_src_a),
        .cmd_src_b  (cmd_src_b),
        .cmd_imm_en (cmd_imm_en),
        .cmd_imm    (cmd_imm),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_dst    (rsp_dst),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    // Behavioural stand-in for the external combinational ALU.
    function automatic logic [3:0] ext_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] sel);
        case (sel)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_DIV:  return (b == 4'h0) ? 4'h0 : a / b;
            OP_EQ:   return (a == b) ? 4'h1 : 4'h0;
            OP_GT:   return (a > b) ? 4'h1 : 4'h0;
            default: return 4'h0;
        endcase
    endfunction

    assign alu_result = ext_alu(alu_a, alu_b, alu_sel);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Response monitor: a handshake happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_dst", rsp_dst, e.dst);
                chk("rsp_carry", rsp_carry, e.carry);
                chk("rsp_zero", rsp_zero, e.zero);
                chk("rsp_err", rsp_err, e.err);
                $display("rsp: data=%h dst=%0d c=%b z=%b e=%b", rsp_data, rsp_dst,
                         rsp_carry, rsp_zero, rsp_err);
            end
        end
    end

    // Computes the expected response from the model register file and
    // applies the write-back (and an optional accept-cycle load) to the model.
    task automatic predict(input logic [3:0] sel, input logic [1:0] dst,
                           input logic [1:0] sa, input logic [1:0] sb,
                           input logic imm_en, input logic [3:0] imm,
                           input logic ld, input logic [1:0] la, input logic [3:0] ldd,
                           output exp_t e, output logic [3:0] a, output logic [3:0] b);
        a = model_rf[sa];
        b = imm_en ? imm : model_rf[sb];
        if (sel == OP_DIV && b == 4'h0) begin
            e.data = 4'hF;
            e.err  = 1'b1;
        end else begin
            e.data = ext_alu(a, b, sel);
            e.err  = 1'b0;
        end
        e.dst   = dst;
        e.carry = (sel == OP_ADD) && ((int'(a) + int'(b)) > 15);
        e.zero  = (e.data == 4'h0);
        sb_q.push_back(e);
        if (ld) model_rf[la] = ldd;
        model_rf[dst] = e.data;
    endtask

    task automatic load(input logic [1:0] addr, input logic [3:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(posedge clk); #1;
        ld_en = 1'b0;
        model_rf[addr] = data;
    endtask

    // Presents one command and returns 1 time unit after its accept edge.
    task automatic drive_cmd(input logic [3:0] sel, input logic [1:0] dst,
                             input logic [1:0] sa, input logic [1:0] sb,
                             input logic imm_en, input logic [3:0] imm,
                             input logic ld, input logic [1:0] la, input logic [3:0] ldd);
        exp_t       e;
        logic [3:0] a, b;
        int         n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("cmd_ready_timeout", 0, 1);
        predict(sel, dst, sa, sb, imm_en, imm, ld, la, ldd, e, a, b);
        $display("cmd: sel=%b dst=%0d a=%h b=%h exp=%h", sel, dst, a, b, e.data);
        cmd_valid  = 1'b1;
        cmd_sel    = sel;
        cmd_dst    = dst;
        cmd_src_a  = sa;
        cmd_src_b  = sb;
        cmd_imm_en = imm_en;
        cmd_imm    = imm;
        ld_en      = ld;
        ld_addr    = la;
        ld_data    = ldd;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ld_en     = 1'b0;
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_sel", alu_sel, sel);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("rsp_timeout", 0, 1);
    endtask

    initial begin
        exp_t       e1, e2;
        logic [3:0] ta, tb;

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_sel = '0; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0;
        cmd_imm_en = 1'b0; cmd_imm = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) model_rf[i] = 4'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_sel", alu_sel, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", cmd_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_edge", cmd_ready, 1);

        // Add R1+R2 -> R3, then read R3 back
        load(2'd1, 4'd3);
        load(2'd2, 4'd5);
        drive_cmd(OP_ADD, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0, 1'b0, 2'd0, 4'd0);
        wait_done();
        drive_cmd(OP_ADD, 2'd3, 2'd3, 2'd0, 1'b1, 4'd0, 1'b0, 2'd0, 4'd0);
        wait_done();

        // Carry out, then equality against an immediate
        load(2'd0, 4'd9);
        load(2'd1, 4'd9);
        drive_cmd(OP_ADD, 2'd0, 2'd0, 2'd1, 1'b0, 4'd0, 1'b0, 2'd0, 4'd0);
        wait_done();
        drive_cmd(OP_EQ, 2'd2, 2'd0, 2'd0, 1'b1, 4'd2, 1'b0, 2'd0, 4'd0);
        wait_done();

        // Divide by zero substitution, read back, then a normal divide
        load(2'd1, 4'd6);
        drive_cmd(OP_DIV, 2'd3, 2'd1, 2'd0, 1'b1, 4'd0, 1'b0, 2'd0, 4'd0);
        wait_done();
        drive_cmd(OP_ADD, 2'd3, 2'd3, 2'd0, 1'b1, 4'd0, 1'b0, 2'd0, 4'd0);
        wait_done();
        drive_cmd(OP_DIV, 2'd3, 2'd1, 2'd0, 1'b1, 4'd2, 1'b0, 2'd0, 4'd0);
        wait_done();

        // Load colliding with the EXEC write-back is dropped
        drive_cmd(OP_SUB, 2'd2, 2'd1, 2'd0, 1'b1, 4'd1, 1'b0, 2'd0, 4'd0);
        ld_en = 1'b1; ld_addr = 2'd2; ld_data = 4'd7;
        @(posedge clk); #1;
        ld_en = 1'b0;
        wait_done();
        drive_cmd(OP_ADD, 2'd0, 2'd2, 2'd0, 1'b1, 4'd0, 1'b0, 2'd0, 4'd0);
        wait_done();

        // Load to a source register in the accept cycle: old value used
        drive_cmd(OP_ADD, 2'd0, 2'd1, 2'd0, 1'b1, 4'd1, 1'b1, 2'd1, 4'd4);
        wait_done();
        drive_cmd(OP_ADD, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0, 1'b0, 2'd0, 4'd0);
        wait_done();

        // Response back-pressure with a second command pending
        rsp_ready = 1'b0;
        drive_cmd(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 4'd3, 1'b0, 2'd0, 4'd0);
        e1 = sb_q[0];
        predict(OP_GT, 2'd2, 2'd1, 2'd0, 1'b0, 4'd0, 1'b0, 2'd0, 4'd0, e2, ta, tb);
        cmd_valid = 1'b1; cmd_sel = OP_GT; cmd_dst = 2'd2; cmd_src_a = 2'd1;
        cmd_src_b = 2'd0; cmd_imm_en = 1'b0; cmd_imm = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_cmd_ready", cmd_ready, 0);
            chk("stall_rsp_data", rsp_data, e1.data);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_ready", cmd_ready, 1);
        chk("post_hs_valid", rsp_valid, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("next_accept_ready", cmd_ready, 0);
        chk("next_accept_sel", alu_sel, OP_GT);
        chk("next_accept_a", alu_a, ta);
        wait_done();

        // Reset while in RESP
        rsp_ready = 1'b0;
        drive_cmd(OP_ADD, 2'd3, 2'd1, 2'd0, 1'b1, 4'd1, 1'b0, 2'd0, 4'd0);
        @(posedge clk); #1;
        chk("resp_valid_pre_rst", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_cmd_ready", cmd_ready, 0);
        chk("arst_alu_a", alu_a, 0);
        chk("arst_rsp_data", rsp_data, 0);
        sb_q.delete();
        for (int i = 0; i < 4; i++) model_rf[i] = 4'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("rel_ready_before_edge", cmd_ready, 0);
        @(posedge clk); #1;
        chk("rel_ready_after_edge", cmd_ready, 1);
        drive_cmd(OP_ADD, 2'd0, 2'd3, 2'd1, 1'b0, 4'd0, 1'b0, 2'd0, 4'd0);
        wait_done();
        drive_cmd(OP_ADD, 2'd1, 2'd2, 2'd0, 1'b0, 4'd0, 1'b0, 2'd0, 4'd0);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Sequencing stage that sits directly upstream of the 4-bit combinational ALU. It accepts operation commands over a valid/ready handshake and reads operands from a private 4x4-bit register file. It drives the ALU's A/B/select inputs, captures the result and writes it back, then returns a response with flags over a second valid/ready handshake. One command is in flight at a time.

## Interface
- No parameters. Widths are fixed: data 4 bits, 4 registers, select 4 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  stage can accept a command.
- cmd_sel  in  4  ALU select code, passed through unchanged (0000 add … 1111 greater-than).
- cmd_dst  in  2  destination register.
- cmd_src_a  in  2  operand A register.
- cmd_src_b  in  2  operand B register.
- cmd_imm_en  in  1  use cmd_imm as B instead of register B.
- cmd_imm  in  4  immediate B.
- ld_en  in  1  direct register-file load strobe.
- ld_addr  in  2  load address.
- ld_data  in  4  load data.
- alu_a  out  4  to ALU A.
- alu_b  out  4  to ALU B.
- alu_sel  out  4  to ALU select.
- alu_result  in  4  from ALU output (combinational).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  4  result as written back.
- rsp_dst  out  2  register written.
- rsp_carry  out  1  bit 4 of {1'b0,A}+{1'b0,B}; valid for select 0000 only, otherwise 0.
- rsp_zero  out  1  rsp_data == 0.
- rsp_err  out  1  divide by zero was substituted.

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch the command, read the operands, drive the alu_* registers, then go to EXEC.
  - EXEC: sample alu_result and apply substitution. Write the value to regfile[dst]. Load rsp_* and set rsp_valid. Go to RESP.
  - RESP: hold all rsp_* stable until rsp_ready=1, then clear rsp_valid and go to IDLE.
- Operands are read from the register file in the IDLE acceptance cycle, using the pre-edge contents.
- If ld_en targets a source register in the same cycle, the old value is used.
- Division: when alu_sel=0011 and alu_b=0, rsp_data=4'hF and rsp_err=1. In every other case rsp_err=0.
- rsp_zero is computed on the final (post-substitution) rsp_data.
- ld_en writes the register file in any state.
  - If it collides with the EXEC write-back to the same address, the write-back wins and the load is dropped.
  - Loads to other addresses proceed in the same cycle.
- alu_a, alu_b and alu_sel are registered and hold their value outside EXEC.
- Reset values:
  - cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_dst=0, all rsp flags=0.
  - alu_a, alu_b and alu_sel = 0.
  - All four registers = 0.
  - State = IDLE.
- cmd_ready rises on the first clock edge after rst_n deasserts.
- Reset asserted mid-operation aborts the command. No write-back happens unless EXEC's edge had already occurred.

## Timing
- Command accepted at edge N. alu_* are valid after N. Write-back and rsp_valid occur at edge N+1.
- Minimum command-to-command spacing is 3 cycles when rsp_ready is held at 1.
- cmd_ready is 0 in EXEC and RESP. A command presented then must be held by the producer.
- The consumer may assert rsp_ready before rsp_valid. The response handshake completes on the edge where both are 1.
- The ALU path is purely combinational between the alu_* registers and the EXEC sample edge: one full cycle.

## Structure
- A shared package `alu_pkg` holds:
  - the select-code constants (ALU_ADD=0000 … ALU_GT=1111, ALU_DIV=0011);
  - the FSM state enum;
  - the DIV0_RESULT=4'hF constant.
- One sub-module, `alu_regfile`, provides:
  - a 4x4 array with asynchronous clear;
  - two combinational read ports and two write ports;
  - write-back priority over the load port on an address collision.
- The FSM and response registers stay in alu_issue. The ALU itself is external and connected through the alu_* ports.

## Test plan
- Load R1=3 and R2=5. Send add, dst=R3, A=R1, B=R2. Expected: alu_a=3, alu_b=5, alu_sel=0000 the cycle after accept; rsp_data=8, carry=0, zero=0; R3 reads 8.
- Load R0=9 and R1=9. Send add into R0. Expected: rsp_data=2, carry=1. Then send equality (1110) with A=R0 and immediate 2. Expected: rsp_data=1.
- Send divide A=R1(6), imm_en=1, imm=0. Expected: rsp_data=F, rsp_err=1, R_dst=F. Then divide by imm 2. Expected: rsp_data=3, err=0.
- Hold rsp_ready=0 for 5 cycles with a new cmd_valid pending. Expected: rsp_* stable, cmd_ready=0, no second write-back. Release and check the next command is accepted 1 cycle after the handshake.
- Fire ld_en to the same address as dst in the EXEC cycle. Expected: the ALU result is stored. Fire ld_en to the source register in the accept cycle. Expected: the old value is used.
- Assert rst_n=0 in RESP. Expected: rsp_valid=0 immediately, all registers 0, cmd_ready=0, then cmd_ready=1 on the first edge after release.
